// File: rtl/sa_pkg.sv
// Shared definitions for the systolic array datapath and its operand feeder.
package sa_pkg;

    localparam int DATA_BITS = 16;

    typedef logic signed [DATA_BITS-1:0] q15_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;

    // Zero-injection cycles needed to drain an N-wide skewed array.
    function automatic int flush_len(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Purpose: enable-gated shift register delaying one operand lane by DEPTH advances.
// Latency: DEPTH enabled cycles from d to q; clr zeroes the line synchronously.
// Backpressure: none; holds contents while en is low.
module skew_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Purpose: stages A/B K-beats into a systolic array with diagonal skew, clear and zero flush.
// Latency: beat reaches lane i output i+1 advances after acceptance; job = 1+K+stalls+2N-2+1 cycles.
// Backpressure: in_ready high only in STREAM; optional stall counter under SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder #(
    parameter int DATA_BITS  = sa_pkg::DATA_BITS,
    parameter int ARRAY_SIZE = 4,
    parameter int K_BITS     = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [K_BITS-1:0]                k_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_BITS-1:0]  a_in_flat,
    input  logic [ARRAY_SIZE*DATA_BITS-1:0]  b_in_flat,
    output logic [ARRAY_SIZE*DATA_BITS-1:0]  a_inputs_flat,
    output logic [ARRAY_SIZE*DATA_BITS-1:0]  b_inputs_flat,
    output logic                             clear_acc,
    output logic                             compute_enable,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      stall_cycles
);
    import sa_pkg::*;

    localparam int N         = ARRAY_SIZE;
    localparam int DB        = DATA_BITS;
    localparam int FLUSH_LEN = flush_len(N);
    localparam int FW        = $clog2(2 * N);

    feeder_state_t     state;
    logic [K_BITS-1:0] k_q;
    logic [K_BITS-1:0] beat_cnt;
    logic [FW-1:0]     flush_cnt;

    logic              beat_acc;
    logic              advance;
    logic              skew_clr;
    logic [N*DB-1:0]   a_beat;
    logic [N*DB-1:0]   b_beat;

    assign beat_acc = in_valid & in_ready;
    assign advance  = beat_acc | (state == FLUSH);
    assign skew_clr = (state == CLEAR);
    // Zeros are injected on every non-beat advance, i.e. throughout FLUSH.
    assign a_beat   = beat_acc ? a_in_flat : '0;
    assign b_beat   = beat_acc ? b_in_flat : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            clear_acc      <= 1'b0;
            compute_enable <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            k_q            <= '0;
            beat_cnt       <= '0;
            flush_cnt      <= '0;
        end else begin
            clear_acc      <= 1'b0;
            done           <= 1'b0;
            compute_enable <= advance;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        clear_acc <= 1'b1;
                        busy      <= 1'b1;
                        k_q       <= k_len;
                        beat_cnt  <= '0;
                    end
                end
                CLEAR: begin
                    if (k_q == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= STREAM;
                        in_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == k_q - 1'b1) begin
                            state     <= FLUSH;
                            in_ready  <= 1'b0;
                            flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Lane i is delayed by i+1 advances, producing the diagonal wavefront.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.WIDTH(DB), .DEPTH(i + 1)) u_skew_a (
            .clk   (clk),
            .reset (reset),
            .en    (advance),
            .clr   (skew_clr),
            .d     (a_beat[i*DB +: DB]),
            .q     (a_inputs_flat[i*DB +: DB])
        );
        skew_delay_line #(.WIDTH(DB), .DEPTH(i + 1)) u_skew_b (
            .clk   (clk),
            .reset (reset),
            .en    (advance),
            .clr   (skew_clr),
            .d     (b_beat[i*DB +: DB]),
            .q     (b_inputs_flat[i*DB +: DB])
        );
    end

`ifdef SYSTOLIC_FEEDER_PERF_EN
    // Cleared when a job is launched so the count reads 0 from CLEAR onward and holds after done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (state == STREAM && !in_valid && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: queue-based reference model plus directed literal checks.
module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DB = 16;
    localparam int KB = 8;
    localparam int W  = N * DB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [KB-1:0] k_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_in_flat = '0;
    logic [W-1:0]  b_in_flat = '0;
    logic [W-1:0]  a_out;
    logic [W-1:0]  b_out;
    logic          clear_acc;
    logic          compute_enable;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cycles;

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_BITS(DB), .ARRAY_SIZE(N), .K_BITS(KB)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .k_len          (k_len),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a_in_flat      (a_in_flat),
        .b_in_flat      (b_in_flat),
        .a_inputs_flat  (a_out),
        .b_inputs_flat  (b_out),
        .clear_acc      (clear_acc),
        .compute_enable (compute_enable),
        .busy           (busy),
        .done           (done),
        .stall_cycles   (stall_cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: job phase plus the ordered list of values injected per advance.
    int           m_phase = 0;   // 0 idle, 1 clear, 2 stream, 3 flush, 4 done
    int           m_k = 0;
    int           m_beats = 0;
    int           m_fl = 0;
    int           m_stall = 0;
    bit           m_ce = 1'b0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_ce    = 1'b0;
            m_stall = 0;
            qa.delete();
            qb.delete();
        end else begin
            m_ce = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_k = int'(k_len); m_beats = 0; m_stall = 0;
                end
                1: begin
                    qa.delete(); qb.delete();
                    m_phase = (m_k == 0) ? 4 : 2;
                end
                2: if (in_valid) begin
                    qa.push_back(a_in_flat); qb.push_back(b_in_flat);
                    m_beats++; m_ce = 1'b1;
                    if (m_beats == m_k) begin m_phase = 3; m_fl = 0; end
                end else if (m_stall < 65535) begin
                    m_stall++;
                end
                3: begin
                    qa.push_back('0); qb.push_back('0);
                    m_ce = 1'b1; m_fl++;
                    if (m_fl == 2 * N - 2) m_phase = 4;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Lane i after p advances shows the value injected at advance p-1-i.
    function automatic logic [W-1:0] skew_view(input bit use_b);
        logic [W-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < N; i++) begin
            idx = (use_b ? qb.size() : qa.size()) - 1 - i;
            if (idx >= 0) r[i*DB +: DB] = use_b ? qb[idx][i*DB +: DB] : qa[idx][i*DB +: DB];
        end
        return r;
    endfunction

    function automatic logic [15:0] exp_stall();
`ifdef SYSTOLIC_FEEDER_PERF_EN
        return 16'(m_stall);
`else
        return 16'd0;
`endif
    endfunction

    int           cyc = 0;
    int           ce_cnt = 0, clr_cnt = 0, done_cnt = 0, acc_cnt = 0, rdy_cnt = 0;
    int           last_acc_cyc = 0, done_cyc = 0, clr_cyc = 0, first_ce_cyc = 0;
    logic [W-1:0] ce_a [16];

    always @(negedge clk) begin
        cyc++;
        chk("busy", W'(busy), W'(m_phase != 0));
        chk("in_ready", W'(in_ready), W'(m_phase == 2));
        chk("clear_acc", W'(clear_acc), W'(m_phase == 1));
        chk("done", W'(done), W'(m_phase == 4));
        chk("compute_enable", W'(compute_enable), W'(m_ce));
        chk("a_inputs", a_out, skew_view(1'b0));
        chk("b_inputs", b_out, skew_view(1'b1));
        chk("stall_cycles", W'(stall_cycles), W'(exp_stall()));
        if (compute_enable) begin
            if (ce_cnt == 0) first_ce_cyc = cyc;
            if (ce_cnt < 16) ce_a[ce_cnt] = a_out;
            ce_cnt++;
        end
        if (clear_acc) begin clr_cnt++; clr_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (in_ready) rdy_cnt++;
        if (in_valid && in_ready) begin acc_cnt++; last_acc_cyc = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        ce_cnt = 0; clr_cnt = 0; rdy_cnt = 0;
    endtask

    // vmode: 0 valid held, 1 random valid, 2 two-cycle gap after first beat.
    // dmode: 0 random data, 1 all lanes 0.5, 2 random A with identity B rows.
    task automatic run_job(input int k, input int vmode, input int dmode, input bit mid_start);
        int d0, acc0, gap, budget;
        bit pulsed;
        logic [W-1:0] t;
        d0 = done_cnt; acc0 = acc_cnt; gap = 0; budget = 0; pulsed = 1'b0;
        start = 1'b1; k_len = KB'(k);
        in_valid = (vmode != 1) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
        tick();
        start = 1'b0;
        while (done_cnt == d0 && budget < 2000) begin
            case (dmode)
                1: begin a_in_flat = {N{16'h4000}}; b_in_flat = {N{16'h4000}}; end
                2: begin
                    a_in_flat = {$urandom, $urandom};
                    t = '0;
                    if (acc_cnt - acc0 < N) t[(acc_cnt - acc0)*DB +: DB] = 16'h7FFF;
                    b_in_flat = t;
                end
                default: begin a_in_flat = {$urandom, $urandom}; b_in_flat = {$urandom, $urandom}; end
            endcase
            case (vmode)
                0: in_valid = 1'b1;
                1: in_valid = 1'($urandom_range(0, 3) != 0);
                default: begin
                    in_valid = 1'b1;
                    if (in_ready && (acc_cnt - acc0) == 1 && gap < 2) begin
                        in_valid = 1'b0; gap++;
                    end
                end
            endcase
            start = 1'b0;
            if (mid_start && !pulsed && in_ready && (acc_cnt - acc0) == 1) begin
                start = 1'b1; k_len = 8'd1; pulsed = 1'b1;
            end
            tick();
            budget++;
        end
        start = 1'b0; in_valid = 1'b0;
        chk("job_completed", W'(done_cnt == d0), W'(0));
    endtask

    int d_save;

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_a", a_out, '0);
        chk("rst_b", b_out, '0);
        chk("rst_ctl", W'({busy, done, clear_acc, compute_enable, in_ready}), W'(0));
        chk("rst_stall", W'(stall_cycles), W'(0));
        @(negedge clk) reset = 1'b0;
        tick();

        // K=1, lane i nonzero only in compute_enable cycle i+1.
        clear_stats();
        run_job(1, 0, 1, 1'b0);
        chk("t1_ce_count", W'(ce_cnt), W'(7));
        for (int c = 0; c < 7; c++)
            for (int i = 0; i < N; i++)
                chk("t1_lane", W'(ce_a[c][i*DB +: DB]), (c == i) ? W'(16'h4000) : W'(0));
        chk("t1_done_delay", W'(done_cyc - last_acc_cyc), W'(7));
        tick();

        // K=4 identity B, back-to-back.
        clear_stats();
        run_job(4, 0, 2, 1'b0);
        chk("t2_ce_count", W'(ce_cnt), W'(10));
        chk("t2_clear_once", W'(clr_cnt), W'(1));
        chk("t2_clear_first", W'(first_ce_cyc - clr_cyc), W'(2));
        tick();

        // K=3 with a two-cycle gap.
        clear_stats();
        run_job(3, 2, 0, 1'b0);
        chk("t3_ce_count", W'(ce_cnt), W'(9));
`ifdef SYSTOLIC_FEEDER_PERF_EN
        chk("t3_stall", W'(stall_cycles), W'(2));
`else
        chk("t3_stall", W'(stall_cycles), W'(0));
`endif
        tick();

        // k_len = 0: CLEAR straight to DONE.
        clear_stats();
        run_job(0, 0, 0, 1'b0);
        chk("t4_ce_never", W'(ce_cnt), W'(0));
        chk("t4_ready_never", W'(rdy_cnt), W'(0));
        chk("t4_done_after_clear", W'(done_cyc - clr_cyc), W'(1));
        tick();

        // start pulsed mid-STREAM must be ignored.
        clear_stats();
        run_job(5, 0, 0, 1'b1);
        chk("t5_ce_count", W'(ce_cnt), W'(11));
        chk("t5_clear_once", W'(clr_cnt), W'(1));
        tick();

        // Reset asserted during FLUSH aborts without done.
        d_save = done_cnt;
        start = 1'b1; k_len = 8'd3; in_valid = 1'b1;
        a_in_flat = {$urandom, $urandom}; b_in_flat = {$urandom, $urandom};
        tick();
        start = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        in_valid = 1'b0;
        chk("t6_in_flush", W'({busy, in_ready, compute_enable}), W'(3'b101));
        reset = 1'b1;
        #2;
        chk("t6_rst_a", a_out, '0);
        chk("t6_rst_b", b_out, '0);
        chk("t6_rst_ctl", W'({busy, done, clear_acc, compute_enable, in_ready}), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) tick();
        chk("t6_no_done", W'(done_cnt), W'(d_save));
        clear_stats();
        run_job(2, 0, 0, 1'b0);
        chk("t6_clean_ce", W'(ce_cnt), W'(8));
        tick();

        // Randomized jobs with random valid gaps.
        for (int j = 0; j < 25; j++) begin
            run_job(int'($urandom_range(1, 12)), 1, 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
